tcm_mem_ram_dp: RTL and testbench

Parametrised single-clock dual-port tightly-coupled memory. It supersedes the fixed 64-bit/13-bit-address TCM RAM with configurable width and depth, a selectable read mode, and an optional output register. It also adds defined same-address collision handling, a post-reset zero-initialisation state machine, and per-port request/valid handshakes. It sits between the core's instruction/data TCM ports and the AXI slave path into TCM.

---
 rtl/tcm_mem_ram_dp.sv | 185 ++++++++++++++++++
 tb/tb_tcm_mem_ram_dp.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_mem_ram_dp.sv
// tcm_mem_ram_dp - single-clock dual-port tightly-coupled memory.
//
// Two symmetric request ports (read every accepted cycle, byte-masked write)
// over a DEPTH x DATA_W array. The array is split into byte lanes, and each
// lane owns its own storage and collision/merge logic. After reset, the
// memory can optionally walk every word to zero before ready_o rises.
//
// Parameters
//   DATA_W    data width (multiple of 8)
//   ADDR_W    word address width, DEPTH = 2**ADDR_W
//   READ_MODE 0 = read-first (pre-edge word), 1 = write-first (merged word)
//   OUT_REG   1 = extra output register (read latency 2 instead of 1)
//   INIT_ZERO 1 = clear the array after reset before accepting requests
//
// Ports
//   clk_i, rst_i                 clock, async active-low reset
//   reqN_i/addrN_i/dataN_i/wrN_i port N request, address, write data, byte enables
//   dataN_o/validN_o             port N read data (held) and one-cycle valid
//   ready_o                      requests are accepted while high

// One byte lane: storage plus per-port read-data selection.
// Port 0 is written last, so it wins a same-address byte collision.
module tcm_mem_ram_dp_lane #(
  parameter int ADDR_W    = 13,
  parameter int READ_MODE = 0
) (
  input  logic                   clk_i,
  input  logic                   init_we,
  input  logic [ADDR_W-1:0]      init_addr,
  input  logic [1:0]             we,
  input  logic [1:0][ADDR_W-1:0] addr,
  input  logic [1:0][7:0]        wdata,
  output logic [1:0][7:0]        rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  // No reset on the array: only the init walk clears it.
  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem[init_addr] <= '0;
    end else begin
      if (we[1]) mem[addr[1]] <= wdata[1];
      if (we[0]) mem[addr[0]] <= wdata[0];
    end
  end

  // Write-first forwards the byte that will land this edge, with the same
  // port-0 priority as the array write above.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem[addr[p]];
      if (READ_MODE != 0) begin
        if (we[1] && addr[1] == addr[p]) rdata[p] = wdata[1];
        if (we[0] && addr[0] == addr[p]) rdata[p] = wdata[0];
      end
    end
  end
endmodule

module tcm_mem_ram_dp #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 13,
  parameter int READ_MODE = 0,
  parameter int OUT_REG   = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [DATA_W-1:0]   data0_i,
  input  logic [DATA_W/8-1:0] wr0_i,
  output logic [DATA_W-1:0]   data0_o,
  output logic                valid0_o,
  input  logic                req1_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [DATA_W-1:0]   data1_i,
  input  logic [DATA_W/8-1:0] wr1_i,
  output logic [DATA_W-1:0]   data1_o,
  output logic                valid1_o,
  output logic                ready_o
);
  localparam int BYTES  = DATA_W / 8;
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_we;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RESET;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // The first edge out of RESET already clears word 0, so the walk ends on
  // the DEPTH-th edge after release with ready_o rising right there.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we    = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (INIT_ZERO != 0) begin
          init_we    = 1'b1;
          init_cnt_d = init_cnt_q + 1'b1;
          state_d    = ST_INIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_INIT: begin
        init_we    = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RESET;
    endcase
  end

  assign ready_o = (state_q == ST_RUN);

  logic [1:0]                   acc;
  logic [1:0][DATA_W-1:0]       rdata;
  logic [BYTES-1:0][1:0][7:0]   lane_rd;
  logic [1:0][DATA_W-1:0]       out_data;
  logic [1:0]                   out_vld;

  assign acc = {req1_i, req0_i} & {2{ready_o}};

  for (genvar b = 0; b < BYTES; b++) begin : g_lane
    tcm_mem_ram_dp_lane #(
      .ADDR_W   (ADDR_W),
      .READ_MODE(READ_MODE)
    ) u_lane (
      .clk_i    (clk_i),
      .init_we  (init_we),
      .init_addr(init_cnt_q),
      .we       ({acc[1] & wr1_i[b], acc[0] & wr0_i[b]}),
      .addr     ({addr1_i, addr0_i}),
      .wdata    ({data1_i[8*b +: 8], data0_i[8*b +: 8]}),
      .rdata    (lane_rd[b])
    );
    assign rdata[0][8*b +: 8] = lane_rd[b][0];
    assign rdata[1][8*b +: 8] = lane_rd[b][1];
  end

  // Per-port read pipeline. Each data stage only loads alongside its valid,
  // so the last stage holds the previous read between pulses.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [STAGES:1]             vld_pipe;
    logic [STAGES:1][DATA_W-1:0] dpipe;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        vld_pipe <= '0;
        dpipe    <= '0;
      end else begin
        vld_pipe[1] <= acc[p];
        if (acc[p]) dpipe[1] <= rdata[p];
        for (int s = 2; s <= STAGES; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          if (vld_pipe[s-1]) dpipe[s] <= dpipe[s-1];
        end
      end
    end

    assign out_vld[p]  = vld_pipe[STAGES];
    assign out_data[p] = dpipe[STAGES];
  end

  assign data0_o  = out_data[0];
  assign valid0_o = out_vld[0];
  assign data1_o  = out_data[1];
  assign valid1_o = out_vld[1];
endmodule

// File: tb/tb_tcm_mem_ram_dp.sv
// Bench for tcm_mem_ram_dp: two instances share one stimulus stream.
//   u_a: READ_MODE=0, OUT_REG=0 (read-first, latency 1)
//   u_b: READ_MODE=1, OUT_REG=1 (write-first, latency 2)
// A word-level model predicts ready/valid/data for both every cycle, and
// directed steps pin the model with hand-computed values.
module tb_tcm_mem_ram_dp;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req0, req1;
  logic [3:0]  a0, a1;
  logic [63:0] d0, d1;
  logic [7:0]  w0, w1;

  logic [63:0] oq [2][2];  // [dut][port]
  logic        ov [2][2];
  logic        ordy [2];

  tcm_mem_ram_dp #(.DATA_W(64), .ADDR_W(4), .READ_MODE(0), .OUT_REG(0), .INIT_ZERO(1)) u_a (
    .clk_i(clk), .rst_i(rst_n),
    .req0_i(req0), .addr0_i(a0), .data0_i(d0), .wr0_i(w0), .data0_o(oq[0][0]), .valid0_o(ov[0][0]),
    .req1_i(req1), .addr1_i(a1), .data1_i(d1), .wr1_i(w1), .data1_o(oq[0][1]), .valid1_o(ov[0][1]),
    .ready_o(ordy[0]));

  tcm_mem_ram_dp #(.DATA_W(64), .ADDR_W(4), .READ_MODE(1), .OUT_REG(1), .INIT_ZERO(1)) u_b (
    .clk_i(clk), .rst_i(rst_n),
    .req0_i(req0), .addr0_i(a0), .data0_i(d0), .wr0_i(w0), .data0_o(oq[1][0]), .valid0_o(ov[1][0]),
    .req1_i(req1), .addr1_i(a1), .data1_i(d1), .wr1_i(w1), .data1_o(oq[1][1]), .valid1_o(ov[1][1]),
    .ready_o(ordy[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [63:0] mm [2][16];
  logic [63:0] cp [16];
  logic [63:0] ed [2][2];
  bit          ev [2][2];
  logic [63:0] pd [2][2];
  bit          pv [2][2];
  logic [63:0] res [2];
  bit          acc [2];
  bit          rdy;
  int          edges;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      rdy = 0; edges = 0;
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          ed[k][p] = '0; ev[k][p] = 0; pd[k][p] = '0; pv[k][p] = 0;
        end
    end else begin
      acc[0] = rdy && req0;
      acc[1] = rdy && req1;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 16; i++) cp[i] = mm[k][i];
        for (int b = 0; b < 8; b++) if (acc[1] && w1[b]) cp[a1][b*8 +: 8] = d1[b*8 +: 8];
        for (int b = 0; b < 8; b++) if (acc[0] && w0[b]) cp[a0][b*8 +: 8] = d0[b*8 +: 8];
        res[0] = (k == 1) ? cp[a0] : mm[k][a0];
        res[1] = (k == 1) ? cp[a1] : mm[k][a1];
        for (int i = 0; i < 16; i++) mm[k][i] = cp[i];
        for (int p = 0; p < 2; p++) begin
          if (k == 0) begin
            ev[k][p] = acc[p];
            if (acc[p]) ed[k][p] = res[p];
          end else begin
            ev[k][p] = pv[k][p];
            if (pv[k][p]) ed[k][p] = pd[k][p];
            pv[k][p] = acc[p];
            if (acc[p]) pd[k][p] = res[p];
          end
        end
      end
      if (!rdy) begin
        edges++;
        if (edges == 16) begin
          rdy = 1;
          for (int k = 0; k < 2; k++) for (int i = 0; i < 16; i++) mm[k][i] = '0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int vcnt [2][2];
  initial begin
    for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) vcnt[k][p] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ready dut%0d", k), {63'd0, ordy[k]}, {63'd0, rdy});
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("valid dut%0d p%0d", k, p), {63'd0, ov[k][p]}, {63'd0, ev[k][p]});
          chk($sformatf("data dut%0d p%0d", k, p), oq[k][p], ed[k][p]);
          if (ov[k][p] === 1'b1) vcnt[k][p]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_in();
    req0 = 0; req1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; w0 = '0; w1 = '0;
  endtask

  task automatic cyc(input bit r0, input logic [3:0] aa0, input logic [63:0] dd0, input logic [7:0] ww0,
                     input bit r1, input logic [3:0] aa1, input logic [63:0] dd1, input logic [7:0] ww1);
    @(negedge clk);
    req0 = r0; a0 = aa0; d0 = dd0; w0 = ww0;
    req1 = r1; a1 = aa1; d1 = dd1; w1 = ww1;
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Counts rising edges from here until ready_o is seen high, bounded.
  task automatic count_ready(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ordy[0] !== 1'b1 && n < 40);
    chk({nm, " edges to ready"}, 64'(n), 64'd16);
    chk({nm, " ready dut1"}, {63'd0, ordy[1]}, 64'd1);
  endtask

  int snap_a, snap_b;

  initial begin
    idle_in();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", {63'd0, ordy[0]}, 64'd0);
    chk("reset valid0", {63'd0, ov[0][0]}, 64'd0);
    chk("reset data0", oq[0][0], 64'd0);
    chk("reset data1 dut1", oq[1][1], 64'd0);

    // Release with a write request held through INIT: it must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1; a0 = 4'd9; d0 = '1; w0 = 8'hFF;
    count_ready("init");
    idle_in();

    // Read every word on port 1: 16 pulses of zero.
    @(posedge clk); #1;
    snap_a = vcnt[0][1]; snap_b = vcnt[1][1];
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 4'(i), 0, 0);
    cyc(1, 4'd9, 0, 0, 0, 0, 0, 0);
    repeat (3) idle_cyc();
    @(posedge clk); #1;
    chk("init read pulses dut0", 64'(vcnt[0][1] - snap_a), 64'd16);
    chk("init read pulses dut1", 64'(vcnt[1][1] - snap_b), 64'd16);

    // Byte enables.
    cyc(1, 4'd3, 64'h1122334455667788, 8'h0F, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd3, 0, 0);
    idle_cyc();
    chk("byte en dut0", oq[0][1], 64'h0000000055667788);
    idle_cyc();
    chk("byte en dut1", oq[1][1], 64'h0000000055667788);

    // Write/write collision, port 0 priority on overlapping bytes.
    cyc(1, 4'd5, {8{8'hAA}}, 8'h0F, 1, 4'd5, {8{8'hBB}}, 8'h3C);
    cyc(1, 4'd5, 0, 0, 0, 0, 0, 0);
    idle_cyc();
    chk("ww collide dut0", oq[0][0], 64'h0000BBBBAAAAAAAA);
    idle_cyc();
    chk("ww collide dut1", oq[1][0], 64'h0000BBBBAAAAAAAA);

    // Read/write collision.
    cyc(1, 4'd7, 64'h1, 8'hFF, 0, 0, 0, 0);
    cyc(1, 4'd7, 64'h2, 8'hFF, 1, 4'd7, 0, 0);
    idle_cyc();
    chk("rw read-first p1", oq[0][1], 64'h1);
    chk("rw read-first p0", oq[0][0], 64'h1);
    idle_cyc();
    chk("rw write-first p1", oq[1][1], 64'h2);
    chk("rw write-first p0", oq[1][0], 64'h2);

    // Back-to-back reads through the latency-2 pipe.
    for (int i = 0; i < 4; i++) cyc(1, 4'(i), 64'(10 + i), 8'hFF, 0, 0, 0, 0);
    repeat (3) idle_cyc();
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        chk($sformatf("pipe valid %0d", i), {63'd0, ov[1][0]}, (i >= 2 && i <= 5) ? 64'd1 : 64'd0);
        if (i >= 2 && i <= 5) chk($sformatf("pipe data %0d", i), oq[1][0], 64'(10 + i - 2));
      end
      if (i < 4) begin
        req0 = 1; a0 = 4'(i); d0 = '0; w0 = '0;
      end else begin
        idle_in();
      end
    end

    // Reset in the middle of INIT.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midinit ready", {63'd0, ordy[0]}, 64'd0);
    chk("midinit data dut0", oq[0][0], 64'd0);
    chk("midinit data dut1", oq[1][0], 64'd0);
    @(negedge clk); rst_n = 1'b1;
    count_ready("reinit");

    // Reset with a read in flight.
    cyc(1, 4'd2, 64'hDEAD, 8'hFF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd2, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("flight valid dut0", {63'd0, ov[0][1]}, 64'd0);
    chk("flight data dut0", oq[0][1], 64'd0);
    chk("flight valid dut1", {63'd0, ov[1][1]}, 64'd0);
    idle_in();
    @(negedge clk); rst_n = 1'b1;
    snap_b = vcnt[1][1];
    count_ready("flight reinit");
    chk("flight no stray", 64'(vcnt[1][1] - snap_b), 64'd0);

    // Array is zero again after the fresh INIT.
    cyc(0, 0, 0, 0, 1, 4'd2, 0, 0);
    repeat (3) idle_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
